// File: rtl/run_monitor.sv
// Run monitor: counts RUN cycles/retirements, halts on retire limit, self-loop or timeout,
// then streams the register file and a data-memory window out. Optional stall counter: MONITOR_PERF_EN.
module run_monitor #(
    parameter int unsigned MAX_CYCLES = 145,
    parameter int unsigned INST_LIMIT = 19,
    parameter int unsigned LOOP_LIMIT = 8,
    parameter int unsigned RF_ENTRIES = 32,
    parameter int unsigned MEM_BASE   = 20,
    parameter int unsigned MEM_WORDS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [9:0]  dm_raddr,
    input  logic [31:0] dm_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_kind,
    output logic [9:0]  dump_index,
    output logic [31:0] dump_data,
    output logic        done,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {S_RUN, S_DUMP_RF, S_DUMP_MEM, S_DONE} state_t;

    localparam logic [9:0] RF_LAST  = 10'(RF_ENTRIES - 1);
    localparam logic [9:0] MEM_FIRST = 10'(MEM_BASE);
    localparam logic [9:0] MEM_LAST = 10'(MEM_BASE + MEM_WORDS - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] loop_count_q, loop_count_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [1:0]  halt_cause_q, halt_cause_d;
    logic        dump_valid_q, dump_valid_d;
    logic        done_q, done_d;
    logic        dump_kind_q, dump_kind_d;
    logic [9:0]  dump_index_q, dump_index_d;
    logic        hit_retire, hit_loop, hit_time;

`ifdef MONITOR_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
`endif

    // Counters only move in RUN, so they freeze once the dump starts.
    always_comb begin
        cycle_count_d  = cycle_count_q;
        retire_count_d = retire_count_q;
        loop_count_d   = loop_count_q;
        last_pc_d      = last_pc_q;
`ifdef MONITOR_PERF_EN
        stall_count_d  = stall_count_q;
`endif
        if (state_q == S_RUN) begin
            cycle_count_d = sat_inc(cycle_count_q);
            if (wb_valid) begin
                retire_count_d = sat_inc(retire_count_q);
                last_pc_d      = wb_pc;
                loop_count_d   = (wb_pc == last_pc_q) ? sat_inc(loop_count_q) : 32'd0;
            end
`ifdef MONITOR_PERF_EN
            else begin
                stall_count_d = sat_inc(stall_count_q);
            end
`endif
        end
    end

    assign hit_retire = (INST_LIMIT != 0) && (retire_count_d == 32'(INST_LIMIT));
    assign hit_loop   = wb_valid && (loop_count_d == 32'(LOOP_LIMIT - 1));
    assign hit_time   = (cycle_count_d == 32'(MAX_CYCLES));

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        dump_valid_d = dump_valid_q;
        done_d       = done_q;
        dump_kind_d  = dump_kind_q;
        dump_index_d = dump_index_q;
        case (state_q)
            S_RUN: begin
                if (hit_retire || hit_loop || hit_time) begin
                    state_d      = S_DUMP_RF;
                    halt_cause_d = hit_retire ? 2'b11 : (hit_loop ? 2'b10 : 2'b01);
                    dump_valid_d = 1'b1;
                    dump_kind_d  = 1'b0;
                    dump_index_d = 10'd0;
                end
            end
            S_DUMP_RF: begin
                if (dump_valid_q && dump_ready) begin
                    if (dump_index_q != RF_LAST) begin
                        dump_index_d = dump_index_q + 10'd1;
                    end else if (MEM_WORDS == 0) begin
                        state_d      = S_DONE;
                        dump_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        state_d      = S_DUMP_MEM;
                        dump_kind_d  = 1'b1;
                        dump_index_d = MEM_FIRST;
                    end
                end
            end
            S_DUMP_MEM: begin
                if (dump_valid_q && dump_ready) begin
                    if (dump_index_q != MEM_LAST) begin
                        dump_index_d = dump_index_q + 10'd1;
                    end else begin
                        state_d      = S_DONE;
                        dump_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            default: begin
                dump_valid_d = 1'b0;
                done_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RUN;
            cycle_count_q  <= 32'd0;
            retire_count_q <= 32'd0;
            loop_count_q   <= 32'd0;
            last_pc_q      <= 32'd0;
            halt_cause_q   <= 2'b00;
            dump_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            dump_kind_q    <= 1'b0;
            dump_index_q   <= 10'd0;
`ifdef MONITOR_PERF_EN
            stall_count_q  <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
            loop_count_q   <= loop_count_d;
            last_pc_q      <= last_pc_d;
            halt_cause_q   <= halt_cause_d;
            dump_valid_q   <= dump_valid_d;
            done_q         <= done_d;
            dump_kind_q    <= dump_kind_d;
            dump_index_q   <= dump_index_d;
`ifdef MONITOR_PERF_EN
            stall_count_q  <= stall_count_d;
`endif
        end
    end

`ifdef MONITOR_PERF_EN
    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

    // Register 0 is architecturally zero whatever the file holds.
    assign rf_raddr     = dump_index_q[4:0];
    assign dm_raddr     = dump_index_q;
    assign dump_data    = dump_kind_q ? dm_rdata :
                          ((dump_index_q == 10'd0) ? 32'd0 : rf_rdata);
    assign dump_valid   = dump_valid_q;
    assign dump_kind    = dump_kind_q;
    assign dump_index   = dump_index_q;
    assign done         = done_q;
    assign halt_cause   = halt_cause_q;
    assign cycle_count  = cycle_count_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: halt causes, dump ordering/backpressure, reset mid-dump.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = 32'd0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [9:0]  dm_raddr;
    logic [31:0] dm_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic        dump_kind;
    logic [9:0]  dump_index;
    logic [31:0] dump_data;
    logic        done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [31:0] stall_count;

`ifdef MONITOR_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic [31:0] rf [0:31];
    logic [31:0] dm [0:1023];
    logic [42:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];
    assign dm_rdata = dm[dm_raddr];

    run_monitor dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_kind(dump_kind), .dump_index(dump_index), .dump_data(dump_data),
        .done(done), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .retire_count(retire_count), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb_valid = 1'b0;
        dump_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        wb_valid = 1'b1;
        wb_pc = pc;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic check_counts(input string tag, input logic [1:0] cause,
                                input logic [31:0] cyc, input logic [31:0] ret, input logic [31:0] stl);
        check({tag, "_cause"}, halt_cause, cause);
        check({tag, "_cycles"}, cycle_count, cyc);
        check({tag, "_retired"}, retire_count, ret);
        check({tag, "_stalls"}, stall_count, stl);
    endtask

    task automatic run_dump(input bit toggle);
        int cyc;
        bit held_valid;
        logic [42:0] held_word;
        logic [42:0] cur;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, 10'(i), (i == 0) ? 32'd0 : rf[i]});
        for (int m = 20; m < 22; m++) exp_q.push_back({1'b1, 10'(m), dm[m]});
        cyc = 0;
        held_valid = 1'b0;
        held_word = '0;
        while (!done && cyc < 400) begin
            dump_ready = toggle ? cyc[0] : 1'b1;
            cur = {dump_kind, dump_index, dump_data};
            if (held_valid) check("dump_hold", cur, held_word);
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) check("dump_extra", 1, 0);
                else check("dump_word", cur, exp_q.pop_front());
                held_valid = 1'b0;
            end else if (dump_valid) begin
                held_valid = 1'b1;
                held_word = cur;
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_budget", cyc < 400, 1);
        check("dump_left", exp_q.size(), 0);
        check("done_set", done, 1);
        check("done_no_valid", dump_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom();
        rf[0] = 32'hDEAD_BEEF;
        rf[8] = 32'h5;
        for (int i = 0; i < 1024; i++) dm[i] = $urandom();
        dm[20] = 32'h7;
        dm[21] = 32'h9;

        // Reset state
        do_reset();
        check("rst_valid", dump_valid, 0);
        check("rst_done", done, 0);
        check("rst_index", dump_index, 0);
        check("rst_kind", dump_kind, 0);
        check_counts("rst", 2'b00, 0, 0, 0);

        // Retire limit with distinct PCs
        for (int k = 0; k < 18; k++) retire(32'h3000 + 32'(4 * k));
        check("ret_prehalt_valid", dump_valid, 0);
        retire(32'h3000 + 32'(4 * 18));
        check("ret_dump_start", dump_valid, 1);
        check("ret_dump_index", dump_index, 0);
        check_counts("ret", 2'b11, 19, 19, 0);
        // Retirements during the dump are ignored; stalled word holds
        for (int k = 0; k < 3; k++) retire(32'h4000);
        check_counts("ret_frozen", 2'b11, 19, 19, 0);
        check("ret_hold_index", dump_index, 0);
        run_dump(1'b0);

        // Self-loop halt
        do_reset();
        for (int k = 0; k < 5; k++) retire(32'h3000 + 32'(4 * k));
        for (int k = 0; k < 3; k++) retire(32'h3048);
        step();
        for (int k = 0; k < 4; k++) retire(32'h3048);
        check("loop_prehalt_valid", dump_valid, 0);
        retire(32'h3048);
        check("loop_dump_start", dump_valid, 1);
        check_counts("loop", 2'b10, 14, 13, PERF ? 32'd1 : 32'd0);

        // Timeout with dump_ready toggling
        do_reset();
        for (int k = 0; k < 144; k++) step();
        check("time_prehalt_valid", dump_valid, 0);
        step();
        check_counts("time", 2'b01, 145, 0, PERF ? 32'd145 : 32'd0);
        run_dump(1'b1);
        step();
        step();
        check("done_held", done, 1);
        check_counts("time_after", 2'b01, 145, 0, PERF ? 32'd145 : 32'd0);

        // Retire limit and loop limit on the same edge
        do_reset();
        for (int k = 0; k < 11; k++) retire(32'h3000 + 32'(4 * k));
        for (int k = 0; k < 8; k++) retire(32'h3100);
        check_counts("both", 2'b11, 19, 19, 0);

        // Reset mid-dump at index 10
        begin
            int cyc = 0;
            dump_ready = 1'b1;
            while (dump_index != 10'd10 && cyc < 100) begin
                step();
                cyc++;
            end
            dump_ready = 1'b0;
            check("abort_reached_10", dump_index, 10);
        end
        rst = 1'b1;
        step();
        check("abort_valid", dump_valid, 0);
        check("abort_index", dump_index, 0);
        check("abort_done", done, 0);
        check_counts("abort", 2'b00, 0, 0, 0);
        rst = 1'b0;
        step();
        check("abort_still_idle", dump_valid, 0);

        // Rerun after abort (one cycle already spent in RUN idle)
        for (int k = 0; k < 19; k++) retire(32'h5000 + 32'(4 * k));
        check_counts("rerun", 2'b11, 20, 19, PERF ? 32'd1 : 32'd0);
        run_dump(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter MAX_CYCLES, default 145, is the cycle budget; a timeout halt occurs when it is reached.
REQ-002 Parameter INST_LIMIT, default 19, is the retired-instruction count that ends the run; a value of 0 disables this halt.
REQ-003 Parameter LOOP_LIMIT, default 8, is the number of consecutive same-PC retirements that flags a self-loop halt.
REQ-004 Parameter RF_ENTRIES, default 32, is the number of register-file words dumped.
REQ-005 Parameter MEM_BASE, default 20, is the first data-memory word index dumped.
REQ-006 Parameter MEM_WORDS, default 2, is the number of data-memory words dumped.
REQ-007 clk  input  1  single system clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wb_valid  input  1  an instruction retires in WB this cycle.
REQ-010 wb_pc  input  32  PC of the retiring instruction.
REQ-011 rf_raddr  output  5  register-file read address (async read port).
REQ-012 rf_rdata  input  32  register-file read data.
REQ-013 dm_raddr  output  10  data-memory word read address (async read port).
REQ-014 dm_rdata  input  32  data-memory read data.
REQ-015 dump_valid  output  1  dump word available.
REQ-016 dump_ready  input  1  consumer accepts the dump word.
REQ-017 dump_kind  output  1  0 = register, 1 = memory.
REQ-018 dump_index  output  10  register number or memory word index.
REQ-019 dump_data  output  32  dumped value.
REQ-020 done  output  1  run and dump complete.
REQ-021 halt_cause  output  2  00 none, 01 timeout, 10 loop, 11 retire limit.
REQ-022 cycle_count  output  32  cycles spent in RUN.
REQ-023 retire_count  output  32  instructions retired in RUN.
REQ-024 stall_count  output  32  RUN cycles with wb_valid=0 (see Configuration).

Function
REQ-025 The FSM SHALL have four states, RUN -> DUMP_RF -> DUMP_MEM -> DONE; DONE is held until rst.
REQ-026 In RUN, cycle_count SHALL increment every cycle and retire_count SHALL increment on each cycle with wb_valid=1.
REQ-027 The loop counter SHALL increment when wb_valid=1 and wb_pc equals the last retired PC; a retirement at a different PC SHALL reset it to 0; cycles with wb_valid=0 SHALL leave it unchanged.
REQ-028 Halt conditions, evaluated on next-state counts: retire_count reaches INST_LIMIT; loop counter reaches LOOP_LIMIT-1 (LOOP_LIMIT equal-PC retirements including the first); cycle_count reaches MAX_CYCLES.
REQ-029 When halt conditions coincide, priority SHALL be retire limit > loop > timeout; halt_cause SHALL be latched in the same edge as RUN->DUMP_RF.
REQ-030 After RUN is left, the counters SHALL freeze and retirements SHALL be ignored.
REQ-031 In the DUMP states, dump_valid=1 and dump_data comes combinationally from the selected read port, except register 0, which SHALL read as 0.
REQ-032 The dump index SHALL advance only on dump_valid&&dump_ready; while dump_ready=0, dump_index, dump_kind and dump_data SHALL hold.
REQ-033 DUMP_RF SHALL cover indices 0..RF_ENTRIES-1; the final accepted word moves to DUMP_MEM at index MEM_BASE.
REQ-034 DUMP_MEM SHALL cover MEM_BASE..MEM_BASE+MEM_WORDS-1; the final accepted word moves to DONE.
REQ-035 MEM_WORDS=0 SHALL skip DUMP_MEM (DUMP_RF goes straight to DONE).
REQ-036 In DONE: done=1 and dump_valid=0.
REQ-037 All 32-bit counters SHALL saturate at 0xFFFFFFFF rather than wrap.

Reset
REQ-038 rst SHALL put the FSM in RUN, clear all counters, the loop counter and the last-PC register, and drive done=0, halt_cause=00, dump_valid=0, dump_index=0 and dump_kind=0.
REQ-039 rst asserted mid-dump SHALL abort the dump immediately with no further dump_valid.

Configuration
REQ-040 With MONITOR_PERF_EN defined, stall_count SHALL increment on RUN cycles with wb_valid=0 and obey REQ-030/REQ-037/REQ-038.
REQ-041 Without MONITOR_PERF_EN, stall_count SHALL be constant 0 and no stall counter logic SHALL be present.

Verification
REQ-042 Bench SHALL cover: INST_LIMIT=19, wb_valid pulsed with distinct PCs 0x3000+4k -> halt_cause=11, retire_count=19, dump begins the next cycle.
REQ-043 Bench SHALL cover: 5 distinct retirements then wb_pc=0x3048 retired 8 times -> halt_cause=10, retire_count=13.
REQ-044 Bench SHALL cover: wb_valid held 0, MAX_CYCLES=145 -> halt_cause=01, cycle_count=145; with MONITOR_PERF_EN, stall_count=145.
REQ-045 Bench SHALL cover: rf r8=0x5, dm[20]=0x7, dm[21]=0x9, dump_ready toggled every other cycle -> 34 words in order r0..r31, m20, m21, r0 reported as 0, no word duplicated or dropped, then done=1.
REQ-046 Bench SHALL cover: retire limit and LOOP_LIMIT reached on the same edge -> halt_cause=11.
REQ-047 Bench SHALL cover: rst asserted at dump index 10 -> next cycle dump_valid=0 and all counters 0, and a rerun completes normally.
